// File: rtl/mixed_width_fifo_ctrl_pkg.sv
// Shared types and helpers for the byte-in / word-out FIFO controller.
package mixed_width_fifo_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    localparam int BYTES_PER_WORD = 4;

    // A word may be read once the byte write pointer has moved past it.
    function automatic logic word_complete(input logic [31:0] wr_words,
                                           input logic [31:0] rd_words);
        return wr_words != rd_words;
    endfunction

endpackage

// File: rtl/mixed_width_fifo_ctrl_if.sv
// Byte-stream input and word-stream output handshakes of the controller.
interface mixed_width_fifo_ctrl_if;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (output s_data, s_valid, m_ready,
                    input  s_ready, m_data, m_valid);
    modport slave  (input  s_data, s_valid, m_ready,
                    output s_ready, m_data, m_valid);
endinterface

// File: rtl/mixed_width_skid_fifo.sv
// Small register FIFO that absorbs RAM read data returning after the
// sink has stalled; the head entry is presented straight from a register.
module mixed_width_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          push,
    input  logic [31:0]   din,
    input  logic          pop,
    output logic [31:0]   dout,
    output logic [CW-1:0] count_o
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]   mem_q [DEPTH];
    logic [IW-1:0] rd_idx_q, wr_idx_q;
    logic [CW-1:0] count_q;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    // Storage, indices and occupancy; clr empties the FIFO in one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
        end else if (clr) begin
            rd_idx_q <= '0;
            wr_idx_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_idx_q] <= din;
                wr_idx_q        <= nxt(wr_idx_q);
            end
            if (pop) rd_idx_q <= nxt(rd_idx_q);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    assign dout    = mem_q[rd_idx_q];
    assign count_o = count_q;

endmodule

// File: rtl/mixed_width_fifo_ctrl.sv
// Streaming FIFO controller around an 8-bit write / 32-bit read RAM:
// byte pointer on port A, word pointer on port B, read-latency skid buffer.
module mixed_width_fifo_ctrl
    import mixed_width_fifo_ctrl_pkg::*;
#(
    parameter int ADDRESS_WIDTH_A = 10,
    parameter int ADDRESS_WIDTH_B = 8,   // ADDRESS_WIDTH_A - 2
    parameter int RD_LATENCY      = 1    // 1 or 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    mixed_width_fifo_ctrl_if.slave     strm,
    output logic [ADDRESS_WIDTH_A:0]   byte_count,
    output logic                       ram_en,
    output logic                       ram_we_a,
    output logic [ADDRESS_WIDTH_A-1:0] ram_addr_a,
    output logic [7:0]                 ram_data_in_a,
    output logic                       ram_we_b,
    output logic [ADDRESS_WIDTH_B-1:0] ram_addr_b,
    input  logic [31:0]                ram_data_out_b
);
    localparam int AWA        = ADDRESS_WIDTH_A;
    localparam int AWB        = ADDRESS_WIDTH_B;
    localparam int WSH        = $clog2(BYTES_PER_WORD);
    localparam int SKID_DEPTH = RD_LATENCY + 1;
    localparam int CW         = $clog2(SKID_DEPTH + 1);

    state_e        state_q, state_d;
    logic [1:0]    flush_cnt_q, flush_cnt_d;
    logic [AWA:0]  wr_ptr_q, wr_ptr_d;
    logic [AWB:0]  rd_ptr_q, rd_ptr_d;
    logic [AWB:0]  cmt_ptr_q, cmt_ptr_d;   // words actually taken by the sink
    logic [RD_LATENCY-1:0] vld_q;          // tags RAM data returning
    logic [CW-1:0] skid_cnt;
    logic [31:0]   skid_dout;
    logic [2:0]    inflight;
    logic [3:0]    credit;
    logic          running, wr_fire, rd_issue, pop, push, skid_clr;

    // Registered pointer difference drives both the count and the full test.
    assign byte_count = wr_ptr_q - {cmt_ptr_q, WSH'(0)};

    assign running      = !rst && (state_q == RUN);
    assign strm.s_ready = running && !byte_count[AWA];
    assign wr_fire      = strm.s_valid && strm.s_ready;
    assign strm.m_valid = running && (skid_cnt != '0);
    assign strm.m_data  = skid_dout;
    assign pop          = strm.m_valid && strm.m_ready;
    assign push         = vld_q[RD_LATENCY-1] && (state_q == RUN);

    assign ram_en        = !rst;
    assign ram_we_a      = wr_fire;
    assign ram_addr_a    = wr_ptr_q[AWA-1:0];
    assign ram_data_in_a = wr_fire ? strm.s_data : 8'h00;
    assign ram_we_b      = 1'b0;
    assign ram_addr_b    = rd_ptr_q[AWB-1:0];

    // Count reads whose data has not yet landed in the skid buffer.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + 3'(vld_q[i]);
    end

    // Issue only if every outstanding read still has a skid slot; a pop in
    // this cycle frees one, which is what sustains one word per cycle.
    assign credit   = 4'(inflight) + 4'(skid_cnt) - 4'(pop);
    assign rd_issue = running
                   && word_complete(32'(wr_ptr_q[AWA:WSH]), 32'(rd_ptr_q))
                   && (credit < 4'(RD_LATENCY + 1));

    // Next state: normal pointer movement in RUN, pointer realignment at the
    // end of FLUSH once all outstanding read data has drained.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cmt_ptr_d   = cmt_ptr_q;
        skid_clr    = 1'b0;
        case (state_q)
            RUN: begin
                if (wr_fire)  wr_ptr_d  = wr_ptr_q + 1'b1;
                if (rd_issue) rd_ptr_d  = rd_ptr_q + 1'b1;
                if (pop)      cmt_ptr_d = cmt_ptr_q + 1'b1;
                if (flush) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 2'(RD_LATENCY - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d   = RUN;
                    wr_ptr_d  = {rd_ptr_q, WSH'(0)};  // drop partial-word bytes
                    cmt_ptr_d = rd_ptr_q;
                    skid_clr  = 1'b1;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // State, pointers and read-valid shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cmt_ptr_q   <= '0;
            vld_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cmt_ptr_q   <= cmt_ptr_d;
            vld_q[0]    <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    mixed_width_skid_fifo #(.DEPTH(SKID_DEPTH), .CW(CW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr     (skid_clr),
        .push    (push),
        .din     (ram_data_out_b),
        .pop     (pop),
        .dout    (skid_dout),
        .count_o (skid_cnt)
    );

endmodule

// File: tb/tb_mixed_width_fifo_ctrl.sv
// Directed bench: two controllers (read latency 1 and 2) with behavioural
// mixed-width RAMs, sharing one stimulus stream.
module tb_mixed_width_fifo_ctrl;
    localparam int L0 = 1;
    localparam int L1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic [7:0] s_data = '0;
    logic s_valid = 1'b0;
    logic m_ready = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mixed_width_fifo_ctrl_if if0 ();
    mixed_width_fifo_ctrl_if if1 ();
    assign if0.s_data = s_data;  assign if1.s_data = s_data;
    assign if0.s_valid = s_valid; assign if1.s_valid = s_valid;
    assign if0.m_ready = m_ready; assign if1.m_ready = m_ready;

    logic [10:0] be0, be1;
    logic en0, en1, wea0, wea1, web0, web1;
    logic [9:0] aa0, aa1;
    logic [7:0] da0, da1, ab0, ab1;
    logic [31:0] dob0, dob1, q1a;

    mixed_width_fifo_ctrl #(.ADDRESS_WIDTH_A(10), .ADDRESS_WIDTH_B(8), .RD_LATENCY(L0)) u0 (
        .clk(clk), .rst(rst), .flush(flush), .strm(if0), .byte_count(be0),
        .ram_en(en0), .ram_we_a(wea0), .ram_addr_a(aa0), .ram_data_in_a(da0),
        .ram_we_b(web0), .ram_addr_b(ab0), .ram_data_out_b(dob0));
    mixed_width_fifo_ctrl #(.ADDRESS_WIDTH_A(10), .ADDRESS_WIDTH_B(8), .RD_LATENCY(L1)) u1 (
        .clk(clk), .rst(rst), .flush(flush), .strm(if1), .byte_count(be1),
        .ram_en(en1), .ram_we_a(wea1), .ram_addr_a(aa1), .ram_data_in_a(da1),
        .ram_we_b(web1), .ram_addr_b(ab1), .ram_data_out_b(dob1));

    // Behavioural RAMs: byte write port A, little-endian word read port B.
    logic [7:0] mem0 [1024];
    logic [7:0] mem1 [1024];
    always @(posedge clk) begin
        if (en0 && wea0) mem0[aa0] <= da0;
        if (en0) dob0 <= {mem0[{ab0, 2'd3}], mem0[{ab0, 2'd2}], mem0[{ab0, 2'd1}], mem0[{ab0, 2'd0}]};
        if (en1 && wea1) mem1[aa1] <= da1;
        if (en1) begin
            q1a  <= {mem1[{ab1, 2'd3}], mem1[{ab1, 2'd2}], mem1[{ab1, 2'd1}], mem1[{ab1, 2'd0}]};
            dob1 <= q1a;
        end
    end

    // Output monitor: collect accepted words, spacing, skid occupancy.
    logic [31:0] got0[$], got1[$];
    int last0 = -1, last1 = -1, bad0 = 0, bad1 = 0, occ0 = 0, occ1 = 0;
    logic stream_on = 1'b0;
    always @(negedge clk) begin
        if (!rst && if0.m_valid && if0.m_ready) begin
            got0.push_back(if0.m_data);
            if (stream_on && last0 >= 0 && cyc - last0 != 4) bad0++;
            last0 = cyc;
        end
        if (!rst && if1.m_valid && if1.m_ready) begin
            got1.push_back(if1.m_data);
            if (stream_on && last1 >= 0 && cyc - last1 != 4) bad1++;
            last1 = cyc;
        end
        if (int'(u0.u_skid.count_o) > occ0) occ0 = int'(u0.u_skid.count_o);
        if (int'(u1.u_skid.count_o) > occ1) occ1 = int'(u1.u_skid.count_o);
    end

    function automatic logic [31:0] wrd(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 5 + 1);
    endfunction

    task automatic do_reset();
        s_valid = 0; m_ready = 0; flush = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        got0.delete(); got1.delete();
    endtask

    // Offers one byte (called at posedge+1); returns at posedge+1 after acceptance.
    task automatic put_byte(input logic [7:0] b);
        logic ok;
        ok = 0; s_valid = 1; s_data = b;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk); ok = if0.s_ready;
            @(posedge clk); #1;
        end
        s_valid = 0;
        checks++;
        if (!ok) begin errors++; $display("FAIL put_byte timeout got s_ready 0 exp 1"); end
    endtask

    task automatic test_reset();
        #2;
        checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b exp 0", if0.m_valid); end
        checks++; if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b exp 0", if0.s_ready); end
        checks++; if (be0 !== 11'd0) begin errors++; $display("FAIL rst_byte_count got %0d exp 0", be0); end
        checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %b exp 0", en0); end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++; if (en0 !== 1'b1) begin errors++; $display("FAIL post_rst_ram_en got %b exp 1", en0); end
        checks++; if (if0.s_ready !== 1'b1) begin errors++; $display("FAIL post_rst_s_ready got %b exp 1", if0.s_ready); end
        checks++; if (web0 !== 1'b0) begin errors++; $display("FAIL ram_we_b got %b exp 0", web0); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] b [4];
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33; b[3] = 8'h44;
        m_ready = 1;
        for (int i = 0; i < 4; i++) put_byte(b[i]);
        for (int c = 0; c <= L0 + 1; c++) begin
            @(negedge clk);
            checks++;
            if (if0.m_valid !== (c == L0 + 1)) begin
                errors++; $display("FAIL basic_latency c=%0d got %b exp %b", c, if0.m_valid, c == L0 + 1);
            end
        end
        checks++; if (if0.m_data !== 32'h44332211) begin errors++; $display("FAIL basic_data got %h exp 44332211", if0.m_data); end
        @(negedge clk);
        checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b exp 0", if0.m_valid); end
        checks++; if (be0 !== 11'd0) begin errors++; $display("FAIL basic_count got %0d exp 0", be0); end
        @(posedge clk); #1;
    endtask

    task automatic test_partial();
        int seen;
        seen = 0;
        m_ready = 1;
        put_byte(8'hA1); put_byte(8'hA2); put_byte(8'hA3);
        repeat (10) begin @(negedge clk); if (if0.m_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL partial_held got %0d valid cycles exp 0", seen); end
        checks++; if (be0 !== 11'd3) begin errors++; $display("FAIL partial_count got %0d exp 3", be0); end
        @(posedge clk); #1;
        put_byte(8'hA4);
        for (int i = 0; i < 6 && !if0.m_valid; i++) @(negedge clk);
        checks++; if (if0.m_valid !== 1'b1) begin errors++; $display("FAIL partial_release got %b exp 1", if0.m_valid); end
        checks++; if (if0.m_data !== 32'hA4A3A2A1) begin errors++; $display("FAIL partial_data got %h exp a4a3a2a1", if0.m_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_full_wrap();
        int n, bad, t;
        logic [31:0] exp_w;
        do_reset();
        for (int i = 0; i < 1024; i++) put_byte(pat(i));
        @(negedge clk);
        checks++; if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL full_s_ready got %b exp 0", if0.s_ready); end
        checks++; if (be0 !== 11'd1024) begin errors++; $display("FAIL full_count got %0d exp 1024", be0); end
        @(posedge clk); #1 m_ready = 1;
        @(negedge clk);
        checks++; if (if0.m_data !== wrd(pat(0), pat(1), pat(2), pat(3))) begin errors++; $display("FAIL full_pop_data got %h", if0.m_data); end
        checks++; if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL pop_same_cycle_s_ready got %b exp 0", if0.s_ready); end
        @(posedge clk); #1 m_ready = 0;
        @(negedge clk);
        checks++; if (if0.s_ready !== 1'b1) begin errors++; $display("FAIL pop_next_s_ready got %b exp 1", if0.s_ready); end
        checks++; if (be0 !== 11'd1020) begin errors++; $display("FAIL pop_count got %0d exp 1020", be0); end
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (aa0 !== 10'(k)) begin errors++; $display("FAIL wrap_addr got %0d exp %0d", aa0, k); end
            put_byte(8'hE0 + 8'(k));
        end
        got0.delete();
        m_ready = 1;
        t = 0;
        while (got0.size() < 256 && t < 400) begin @(negedge clk); t++; end
        repeat (3) @(negedge clk);
        checks++; if (got0.size() != 256) begin errors++; $display("FAIL wrap_words got %0d exp 256", got0.size()); end
        checks++; if (t > 258) begin errors++; $display("FAIL drain_rate got %0d cycles exp <=258", t); end
        bad = 0;
        n = (got0.size() < 256) ? got0.size() : 256;
        for (int j = 0; j < n; j++) begin
            exp_w = (j == 255) ? 32'hE3E2E1E0 : wrd(pat(4*j+4), pat(4*j+5), pat(4*j+6), pat(4*j+7));
            if (got0[j] !== exp_w) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order got %0d bad words exp 0", bad); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        int b0, b1, t;
        do_reset();
        last0 = -1; last1 = -1; bad0 = 0; bad1 = 0;
        stream_on = 1; m_ready = 1;
        for (int i = 0; i < 4096; i++) put_byte(8'(i));
        t = 0;
        while ((got0.size() < 1024 || got1.size() < 1024) && t < 50) begin @(negedge clk); t++; end
        stream_on = 0;
        checks++; if (got0.size() != 1024) begin errors++; $display("FAIL stream_l1_words got %0d exp 1024", got0.size()); end
        checks++; if (got1.size() != 1024) begin errors++; $display("FAIL stream_l2_words got %0d exp 1024", got1.size()); end
        b0 = 0; b1 = 0;
        for (int j = 0; j < 1024; j++) begin
            if (j < got0.size() && got0[j] !== wrd(8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3))) b0++;
            if (j < got1.size() && got1[j] !== wrd(8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3))) b1++;
        end
        checks++; if (b0 != 0) begin errors++; $display("FAIL stream_l1_data got %0d bad exp 0", b0); end
        checks++; if (b1 != 0) begin errors++; $display("FAIL stream_l2_data got %0d bad exp 0", b1); end
        checks++; if (bad0 != 0) begin errors++; $display("FAIL stream_l1_gaps got %0d exp 0", bad0); end
        checks++; if (bad1 != 0) begin errors++; $display("FAIL stream_l2_gaps got %0d exp 0", bad1); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic done;
        int bad, t;
        do_reset();
        occ0 = 0; occ1 = 0; done = 0;
        fork
            begin
                for (int i = 0; i < 200; i++) put_byte(8'(i * 3));
                done = 1;
            end
            begin
                while (!done) begin @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1)); end
            end
        join
        m_ready = 1;
        t = 0;
        while ((got0.size() < 50 || got1.size() < 50) && t < 200) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        checks++; if (got0.size() != 50) begin errors++; $display("FAIL bp_l1_words got %0d exp 50", got0.size()); end
        checks++; if (got1.size() != 50) begin errors++; $display("FAIL bp_l2_words got %0d exp 50", got1.size()); end
        bad = 0;
        for (int j = 0; j < 50; j++) begin
            if (j < got0.size() && got0[j] !== wrd(8'(12*j), 8'(12*j+3), 8'(12*j+6), 8'(12*j+9))) bad++;
            if (j < got1.size() && got1[j] !== wrd(8'(12*j), 8'(12*j+3), 8'(12*j+6), 8'(12*j+9))) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_data got %0d bad exp 0", bad); end
        checks++; if (occ0 > L0 + 1) begin errors++; $display("FAIL bp_l1_occupancy got %0d exp <=%0d", occ0, L0 + 1); end
        checks++; if (occ1 > L1 + 1) begin errors++; $display("FAIL bp_l2_occupancy got %0d exp <=%0d", occ1, L1 + 1); end
        @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int t;
        do_reset();
        for (int i = 0; i < 9; i++) put_byte(8'(i + 1));
        s_valid = 1; s_data = 8'h0A; flush = 1;
        @(negedge clk);
        checks++; if (if0.s_ready !== 1'b1) begin errors++; $display("FAIL flush_entry_s_ready got %b exp 1", if0.s_ready); end
        @(posedge clk); #1 s_valid = 0; flush = 1;  // held flush is ignored
        for (int c = 0; c < L0; c++) begin
            @(negedge clk);
            checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL flush_m_valid got %b exp 0", if0.m_valid); end
            checks++; if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL flush_s_ready got %b exp 0", if0.s_ready); end
            @(posedge clk); #1 flush = 0;
        end
        @(negedge clk);
        checks++; if (be0 !== 11'd0) begin errors++; $display("FAIL flush_count got %0d exp 0", be0); end
        checks++; if (if0.s_ready !== 1'b1) begin errors++; $display("FAIL flush_exit_s_ready got %b exp 1", if0.s_ready); end
        checks++; if (aa0 !== 10'd8) begin errors++; $display("FAIL flush_wr_realign got %0d exp 8", aa0); end
        checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL flush_skid_clear got %b exp 0", if0.m_valid); end
        @(posedge clk); #1;
        got0.delete(); m_ready = 1;
        put_byte(8'hAA); put_byte(8'hBB); put_byte(8'hCC); put_byte(8'hDD);
        t = 0;
        while (got0.size() < 1 && t < 8) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        checks++; if (got0.size() != 1) begin errors++; $display("FAIL flush_new_words got %0d exp 1", got0.size()); end
        checks++; if (got0.size() > 0 && got0[0] !== 32'hDDCCBBAA) begin errors++; $display("FAIL flush_new_data got %h exp ddccbbaa", got0[0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) put_byte(8'h70 + 8'(i));
        repeat (3) @(negedge clk);
        checks++; if (if0.m_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", if0.m_valid); end
        #1 s_valid = 1; s_data = 8'h5A; rst = 1;
        #1;
        checks++; if (if0.m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid got %b exp 0", if0.m_valid); end
        checks++; if (if0.m_data !== 32'd0) begin errors++; $display("FAIL mid_m_data got %h exp 0", if0.m_data); end
        checks++; if (if0.s_ready !== 1'b0) begin errors++; $display("FAIL mid_s_ready got %b exp 0", if0.s_ready); end
        checks++; if (be0 !== 11'd0) begin errors++; $display("FAIL mid_count got %0d exp 0", be0); end
        checks++; if (wea0 !== 1'b0 || da0 !== 8'd0) begin errors++; $display("FAIL mid_port_a got we %b data %h exp 0 0", wea0, da0); end
        checks++; if (aa0 !== 10'd0 || ab0 !== 8'd0) begin errors++; $display("FAIL mid_addr got %0d %0d exp 0 0", aa0, ab0); end
        checks++; if (en0 !== 1'b0) begin errors++; $display("FAIL mid_ram_en got %b exp 0", en0); end
        s_valid = 0;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++; if (en0 !== 1'b1 || be0 !== 11'd0) begin errors++; $display("FAIL mid_release got en %b count %0d exp 1 0", en0, be0); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_full_wrap();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
